noise_control: RTL and testbench

Control unit for `datapath_noise`. It turns a note gate into the `en_noise`/`s_noise` command sequence that drives the noise datapath: first one seed-load cycle, then one LFSR advance every `div` clock cycles. Alongside the commands it produces a per-sample valid strobe and a sample counter. It sits between the voice/gate logic and `datapath_noise`, and its outputs connect directly to the datapath's `en_noise` and `s_noise` inputs.

---
 rtl/noise_control_if.sv | 22 ++
 rtl/noise_control.sv | 59 +++++
 tb/tb_noise_control.sv | 93 +++++++++
 3 files changed

// File: rtl/noise_control_if.sv
// noise_control_if: gate/command bundle between the voice logic, noise_control and datapath_noise
interface noise_control_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  logic             gate;
  logic             reseed;
  logic [DIV_W-1:0] div;
  logic             en_noise;
  logic             s_noise;
  logic             sample_valid;
  logic [CNT_W-1:0] sample_count;
  logic             busy;
  modport master (
    output gate, reseed, div,
    input  en_noise, s_noise, sample_valid, sample_count, busy
  );
  modport slave (
    input  gate, reseed, div,
    output en_noise, s_noise, sample_valid, sample_count, busy
  );
endinterface

// File: rtl/noise_control.sv
// noise_control: turns a note gate into seed-load / divided LFSR-advance commands for datapath_noise
module noise_control #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  noise_control_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_eff_q, div_eff_d, div_in;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_eff_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_eff_q <= div_eff_d;
      count_q   <= count_d;
      valid_q   <= en;
    end
  end
  // gate-off wins over reseed; reseed only matters in RUN
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.gate ? SEED : IDLE) :
              !bus.gate         ? IDLE :
              (state_q == SEED) ? RUN  :
              bus.reseed        ? SEED : RUN;
  end
  assign div_in = (bus.div == '0) ? DIV_W'(1) : bus.div;
  always_comb begin
    div_eff_d = div_eff_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    if (state_q == SEED) begin
      div_eff_d = div_in;
      cnt_d     = div_in - DIV_W'(1);
      count_d   = '0;
    end else if (state_q == RUN) begin
      cnt_d   = (cnt_q == '0) ? div_eff_q - DIV_W'(1) : cnt_q - DIV_W'(1);
      count_d = (cnt_q == '0) ? count_q + CNT_W'(1) : count_q;
    end
  end
  always_comb begin
    en               = (state_q == SEED) || ((state_q == RUN) && (cnt_q == '0));
    bus.en_noise     = en;
    bus.s_noise      = (state_q == RUN);
    bus.busy         = (state_q != IDLE);
    bus.sample_valid = valid_q;
    bus.sample_count = count_q;
  end
endmodule

// File: tb/tb_noise_control.sv
// tb_noise_control: random and directed stimulus checked against a period/phase model of the noise controller
module tb_noise_control;
  logic clk, rst_n;
  int total = 0, bad = 0;
  int mode, k, p;
  logic [3:0] cm;
  logic sv_m;
  noise_control_if #(.DIV_W(8), .CNT_W(4)) bus ();
  noise_control #(.DIV_W(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // mode 0 off, 1 seed cycle, 2 running; k = cycles since the seed cycle, p = latched period
  function automatic bit en_m();
    return (mode == 1) || (mode == 2 && (k % p) == 0);
  endfunction
  task automatic check_all(input string tag);
    check({tag, ".en"}, 32'(bus.en_noise), 32'(en_m()));
    check({tag, ".s"}, 32'(bus.s_noise), 32'(mode == 2));
    check({tag, ".busy"}, 32'(bus.busy), 32'(mode != 0));
    check({tag, ".valid"}, 32'(bus.sample_valid), 32'(sv_m));
    check({tag, ".count"}, 32'(bus.sample_count), 32'(cm));
  endtask
  task automatic step(input string tag, input logic g, input logic r, input logic [7:0] d);
    bit e;
    bus.gate = g;
    bus.reseed = r;
    bus.div = d;
    @(posedge clk);
    e = en_m();
    if (mode == 2 && e) cm++;
    sv_m = e;
    case (mode)
      0: mode = g ? 1 : 0;
      1: begin
        p = (d == 0) ? 1 : int'(d);
        cm = 0;
        if (g) begin mode = 2; k = 1; end else mode = 0;
      end
      default: if (!g) mode = 0; else if (r) mode = 1; else k++;
    endcase
    #1 check_all(tag);
    @(negedge clk);
  endtask
  task automatic do_reset(input logic g);
    rst_n = 0;
    bus.gate = g;
    bus.reseed = 0;
    #1;
    mode = 0; k = 0; cm = 0; sv_m = 0;
    check_all("reset");
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    rst_n = 1;
    #1 check("release.busy", 32'(bus.busy), 32'(0));
  endtask
  initial begin
    clk = 0; rst_n = 0; bus.gate = 0; bus.reseed = 0; bus.div = 0;
    p = 1;
    do_reset(0);
    step("idle", 0, 0, 1);
    for (int i = 0; i < 22; i++) step("div1", 1, 0, 1);
    do_reset(1);
    step("gate_hold_idle", 1, 0, 1);
    check("gate_hold_seed.s", 32'(bus.s_noise), 32'(0));
    check("gate_hold_seed.en", 32'(bus.en_noise), 32'(1));
    for (int i = 0; i < 6; i++) step("post_reset", 1, 0, 1);
    step("off", 0, 0, 4);
    for (int i = 0; i < 16; i++) step("div4", 1, 0, 4);
    step("off", 0, 0, 0);
    for (int i = 0; i < 5; i++) step("div0", 1, 0, 0);
    for (int i = 0; i < 8; i++) step("div_chg", 1, 0, 8);
    step("off", 0, 0, 3);
    for (int i = 0; i < 7; i++) step("div3", 1, 0, 3);
    step("reseed", 1, 1, 3);
    check("reseed.s", 32'(bus.s_noise), 32'(0));
    check("reseed.en", 32'(bus.en_noise), 32'(1));
    for (int i = 0; i < 7; i++) step("after_reseed", 1, 0, 3);
    step("gate_off_reseed", 0, 1, 3);
    check("gate_off.busy", 32'(bus.busy), 32'(0));
    for (int i = 0; i < 3; i++) step("idle_hold", 0, 1, 3);
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom % 8) != 0, ($urandom % 10) == 0, 8'($urandom_range(0, 5)));
    do_reset(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
